// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among NUM_REQ producers,
// with occupancy tracking so a write is never issued into a full FIFO.
module fifo_write_arbiter_lane #(
  parameter int DATA_W = 8
) (
  input  logic              req,
  input  logic              granted,
  input  logic              win,
  input  logic [DATA_W-1:0] data,
  output logic              elig,
  output logic [DATA_W-1:0] data_sel
);
  // A lane granted this cycle sits out one edge so a still-held req cannot double-write.
  assign elig     = req & ~granted;
  assign data_sel = {DATA_W{win}} & data;
endmodule

module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int CNT_W   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      read_en,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      write_en,
  output logic [DATA_W-1:0]         data_out,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty,
  output logic                      underflow
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]                ptr, ptr_next;
  logic [NUM_REQ-1:0]              elig, gnt_next;
  logic [NUM_REQ-1:0][DATA_W-1:0]  lane_data, lane_sel;
  logic [DATA_W-1:0]               data_next;
  logic [CNT_W-1:0]                cnt_next;
  logic                            rd_ok;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      assign lane_data[g] = req_data[g*DATA_W +: DATA_W];
      fifo_write_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
        .req      (req[g]),
        .granted  (grant[g]),
        .win      (gnt_next[g]),
        .data     (lane_data[g]),
        .elig     (elig[g]),
        .data_sel (lane_sel[g])
      );
    end
  endgenerate

  assign rd_ok    = read_en && (count != '0);
  assign cnt_next = count + CNT_W'(write_en) - CNT_W'(rd_ok);

  // Gating on cnt_next lets a grant issue in the same cycle a read frees a slot.
  always_comb begin
    int idx;
    logic found;
    logic [PTR_W-1:0] idx_w;
    gnt_next = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    idx_w    = '0;
    if (cnt_next < DEPTH_C) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx   = (int'(ptr) + k) % NUM_REQ;
        idx_w = PTR_W'(idx);
        if (!found && elig[idx_w]) begin
          found           = 1'b1;
          gnt_next[idx_w] = 1'b1;
          ptr_next        = PTR_W'((idx + 1) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    data_next = '0;
    for (int k = 0; k < NUM_REQ; k++) data_next = data_next | lane_sel[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      write_en  <= 1'b0;
      data_out  <= '0;
      underflow <= 1'b0;
      count     <= '0;
      ptr       <= '0;
    end else begin
      grant     <= gnt_next;
      write_en  <= |gnt_next;
      underflow <= read_en && (count == '0);
      count     <= cnt_next;
      ptr       <= ptr_next;
      if (|gnt_next) data_out <= data_next;
    end
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized producers/consumer
// checked every cycle against a transaction-level occupancy/round-robin model.
module tb_fifo_write_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam int CW = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            read_en = 1'b0;
  logic [N-1:0]    grant;
  logic            write_en;
  logic [DW-1:0]   data_out;
  logic [CW-1:0]   count;
  logic            full, empty, underflow;

  int tests = 0;
  int fails = 0;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .read_en(read_en),
    .grant(grant), .write_en(write_en), .data_out(data_out), .count(count),
    .full(full), .empty(empty), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: occupancy as an integer, last winner as an index (-1 = none).
  typedef struct {
    int cnt; int ptr; int gi; int data; int uf;
  } mstate_t;

  function automatic mstate_t mstep(mstate_t s, logic [N-1:0] rq, logic [N*DW-1:0] rdat, logic rd);
    mstate_t n;
    int cn, ng, i;
    n = s;
    n.uf = (rd && s.cnt == 0) ? 1 : 0;
    cn = s.cnt + ((s.gi >= 0) ? 1 : 0) - ((rd && s.cnt > 0) ? 1 : 0);
    ng = -1;
    if (cn < DEPTH)
      for (int k = 0; k < N; k++) begin
        i = (s.ptr + k) % N;
        if (ng < 0 && rq[i] && i != s.gi) ng = i;
      end
    n.cnt = cn;
    n.gi = ng;
    if (ng >= 0) begin
      n.data = int'(rdat[ng*DW +: DW]);
      n.ptr = (ng + 1) % N;
    end
    return n;
  endfunction

  mstate_t m = '{0, 0, -1, 0, 0};
  localparam mstate_t M_RST = '{0, 0, -1, 0, 0};

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= M_RST;
    else        m <= mstep(m, req, req_data, read_en);
  end

  always @(negedge clk) begin
    chk("grant", int'(grant), (m.gi >= 0) ? (1 << m.gi) : 0);
    chk("write_en", int'(write_en), (m.gi >= 0) ? 1 : 0);
    if (m.gi >= 0) chk("data_out", int'(data_out), m.data);
    chk("count", int'(count), m.cnt);
    chk("full", int'(full), (m.cnt == DEPTH) ? 1 : 0);
    chk("empty", int'(empty), (m.cnt == 0) ? 1 : 0);
    chk("underflow", int'(underflow), m.uf);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req = '0; read_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    logic [7:0] d;
    repeat (2) step();
    reset = 1'b1;

    // Round robin with all four requesting.
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_grant", int'(grant), 1 << (k % 4));
      chk("rr_data", int'(data_out), 'hA0 + (k % 4));
    end
    req = '0;
    step();
    chk("rr_count", int'(count), 8);

    // Asynchronous reset in the middle of a burst.
    req = 4'b1111;
    step(); step();
    #2 reset = 1'b0;
    #1;
    chk("arst_grant", int'(grant), 0);
    chk("arst_write_en", int'(write_en), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    req = '0;
    step();
    reset = 1'b1;

    // Single producer: alternate-cycle grants.
    do_reset();
    req_data = {8'h00, 8'h5C, 8'h00, 8'h00};
    req = 4'b0100;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("single_grant", int'(grant), (k % 2 == 0) ? 4 : 0);
      if (grant != '0) n++;
    end
    req = '0;
    chk("single_writes", n, 3);
    chk("single_count", int'(count), 3);

    // Fill to full, then free one slot.
    do_reset();
    req_data = {8'h00, 8'h00, 8'h11, 8'h22};
    req = 4'b0011;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      step();
      if (full) ok = 1'b1;
    end
    chk("fill_reached_full", int'(ok), 1);
    chk("fill_count", int'(count), 32);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_no_write", int'(write_en), 0);
      chk("full_hold", int'(count), 32);
    end
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("refill_write", int'(write_en), 1);
    chk("refill_mid_count", int'(count), 31);
    step();
    chk("refill_count", int'(count), 32);
    chk("refill_full", int'(full), 1);
    req = '0;

    // Simultaneous read and write at count 10.
    do_reset();
    req = 4'b0011;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      step();
      if (count == 6'd10) ok = 1'b1;
    end
    chk("rw_reached_10", int'(ok), 1);
    chk("rw_write_active", int'(write_en), 1);
    req = '0; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("rw_count", int'(count), 10);
    step();
    chk("rw_count_hold", int'(count), 10);

    // Underflow on empty.
    do_reset();
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("uf_pulse", int'(underflow), 1);
    chk("uf_count", int'(count), 0);
    chk("uf_empty", int'(empty), 1);
    step();
    chk("uf_clear", int'(underflow), 0);

    // Randomized producers obeying the hold-until-grant handshake.
    do_reset();
    for (int c = 0; c < 1600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          d = 8'($urandom);
          req_data[i*DW +: DW] = d;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          d = 8'($urandom);
          req_data[i*DW +: DW] = d;
        end
      end
      if (c < 700) read_en = ($urandom_range(0, 2) == 0);
      else         read_en = ($urandom_range(0, 3) != 0);
      if (c == 1000) begin
        #2 reset = 1'b0;
        req = '0;
        #1 reset = 1'b1;
      end
      step();
    end
    req = '0; read_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
